// File: rtl/pb_operand_loader_pkg.sv
// pb_operand_loader_pkg: operand count/width and loader state shared by the loader and the adder
package pb_operand_loader_pkg;
    localparam int N_OPERANDS = 5;
    localparam int OPERAND_W  = 4;
    typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} loader_state_t;
endpackage

// File: rtl/pb_debounce.sv
// pb_debounce: two-flop synchroniser plus counting debouncer for one pushbutton
// Ports: clk, rst (sync, active-high), raw (async button), db (accepted level),
//        rise (high in the cycle whose closing edge moves db from 0 to 1)
module pb_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic db,
    output logic rise
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    logic s1, s2, done;
    logic [CW-1:0] cnt;
    assign done = (s2 != db) && (cnt == LAST);
    // combinational so the operand capture lands on the same edge as db
    assign rise = done && s2;
    always_ff @(posedge clk) begin
        if (rst) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            db  <= 1'b0;
            cnt <= '0;
        end else begin
            s1  <= raw;
            s2  <= s1;
            db  <= done ? s2 : db;
            cnt <= (s2 == db || done) ? '0 : cnt + 1'b1;
        end
    end
endmodule

// File: rtl/pb_operand_loader.sv
// pb_operand_loader: debounces five buttons and latches the slider into each button's operand
// Ports: clk, rst (sync, active-high), pb[4:0] raw buttons, y slider, clr sync clear,
//        x0..x4 operands, loaded flags, load_pulse strobes, all_loaded (state FULL)
module pb_operand_loader
    import pb_operand_loader_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_OPERANDS-1:0] pb,
    input  logic [OPERAND_W-1:0]  y,
    input  logic                  clr,
    output logic [OPERAND_W-1:0]  x0,
    output logic [OPERAND_W-1:0]  x1,
    output logic [OPERAND_W-1:0]  x2,
    output logic [OPERAND_W-1:0]  x3,
    output logic [OPERAND_W-1:0]  x4,
    output logic [N_OPERANDS-1:0] loaded,
    output logic [N_OPERANDS-1:0] load_pulse,
    output logic                  all_loaded
);
    logic [N_OPERANDS-1:0] press, db_unused, nl;
    logic [OPERAND_W-1:0]  x [N_OPERANDS];
    loader_state_t state, state_n;
    for (genvar i = 0; i < N_OPERANDS; i++) begin : g_db
        pb_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk (clk),
            .rst (rst),
            .raw (pb[i]),
            .db  (db_unused[i]),
            .rise(press[i])
        );
    end
    assign nl = loaded | press;
    always_comb state_n = (&nl) ? FULL : (|nl) ? PARTIAL : EMPTY;
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int j = 0; j < N_OPERANDS; j++) x[j] <= '0;
            loaded     <= '0;
            load_pulse <= '0;
            state      <= EMPTY;
        end else begin
            for (int j = 0; j < N_OPERANDS; j++) if (press[j]) x[j] <= y;
            loaded     <= nl;
            load_pulse <= press;
            state      <= state_n;
        end
    end
    assign all_loaded = (state == FULL);
    assign {x4, x3, x2, x1, x0} = {x[4], x[3], x[2], x[1], x[0]};
endmodule

// File: tb/tb_pb_operand_loader.sv
// tb_pb_operand_loader: randomized and directed stimulus against a stream-level reference model
module tb_pb_operand_loader;
    localparam int D = 4;
    logic clk = 0, rst = 1, clr = 0;
    logic [4:0] pb = 0, loaded, load_pulse;
    logic [3:0] y = 0, x0, x1, x2, x3, x4;
    logic all_loaded;
    int checks = 0, failures = 0;

    pb_operand_loader #(.DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .rst(rst), .pb(pb), .y(y), .clr(clr),
        .x0(x0), .x1(x1), .x2(x2), .x3(x3), .x4(x4),
        .loaded(loaded), .load_pulse(load_pulse), .all_loaded(all_loaded)
    );

    always #5 clk = ~clk;

    typedef struct { logic [4:0] p; logic [19:0] x; logic [4:0] l; } exp_t;
    exp_t q[$];

    // reference: button level seen two edges late; accepted level flips after D consecutive differing samples
    logic [4:0] m_s1, m_s2, m_db, m_press, m_loaded;
    int m_run[5];
    logic [3:0] m_x[5];

    function automatic logic [19:0] mxp();
        return {m_x[4], m_x[3], m_x[2], m_x[1], m_x[0]};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_s1 = 0; m_s2 = 0; m_db = 0; m_loaded = 0;
            for (int i = 0; i < 5; i++) begin m_run[i] = 0; m_x[i] = 0; end
        end else begin
            m_press = 0;
            for (int i = 0; i < 5; i++) begin
                if (m_s2[i] != m_db[i]) begin
                    m_run[i]++;
                    if (m_run[i] == D) begin
                        m_db[i] = m_s2[i];
                        m_run[i] = 0;
                        m_press[i] = m_db[i];
                    end
                end else m_run[i] = 0;
            end
            m_s2 = m_s1;
            m_s1 = pb;
            if (clr) begin
                m_loaded = 0;
                for (int i = 0; i < 5; i++) m_x[i] = 0;
            end else if (m_press != 0) begin
                for (int i = 0; i < 5; i++) if (m_press[i]) m_x[i] = y;
                m_loaded |= m_press;
                q.push_back('{p: m_press, x: mxp(), l: m_loaded});
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // monitor: every cycle check held outputs; on each pulse pop the scoreboard
    always @(negedge clk) begin
        exp_t e;
        chk("operands", 32'({x4, x3, x2, x1, x0}), 32'(mxp()));
        chk("loaded", 32'(loaded), 32'(m_loaded));
        chk("all_loaded", 32'(all_loaded), 32'(&m_loaded));
        if (load_pulse != 0 || q.size() != 0) begin
            if (q.size() == 0) chk("unexpected_pulse", 32'(load_pulse), 32'h0);
            else begin
                e = q.pop_front();
                chk("pulse", 32'(load_pulse), 32'(e.p));
                chk("pulse_operands", 32'({x4, x3, x2, x1, x0}), 32'(e.x));
                chk("pulse_loaded", 32'(loaded), 32'(e.l));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [4:0] m, input logic [3:0] v);
        y = v; pb |= m; cyc(D + 6);
        pb &= ~m; cyc(D + 6);
    endtask

    initial begin
        cyc(3); rst = 0;
        cyc(10);
        chk("reset_loaded", 32'(loaded), 32'h0);
        chk("reset_all_loaded", 32'(all_loaded), 32'h0);
        press(5'b00001, 4'hF);
        chk("x0_loaded", 32'(x0), 32'hF);
        chk("loaded_one", 32'(loaded), 32'h01);
        y = 4'h7; pb[2] = 1; cyc(3); pb[2] = 0; cyc(10);
        chk("glitch_loaded", 32'(loaded), 32'h01);
        for (int i = 0; i < 5; i++) press(5'(1 << i), 4'hA);
        chk("all_full", 32'(all_loaded), 32'h1);
        chk("all_A", 32'({x4, x3, x2, x1, x0}), 32'hAAAAA);
        press(5'b00010, 4'h3);
        chk("x1_over", 32'(x1), 32'h3);
        chk("still_full", 32'(all_loaded), 32'h1);
        press(5'b11000, 4'h5);
        chk("x3x4", 32'({x4, x3}), 32'h55);
        y = 4'h9; pb[0] = 1; cyc(D + 1); clr = 1; cyc(1); clr = 0;
        cyc(20);
        chk("clr_loaded", 32'(loaded), 32'h0);
        chk("clr_x0", 32'(x0), 32'h0);
        pb[0] = 0; cyc(D + 6);
        press(5'b00001, 4'h6);
        chk("repress_x0", 32'(x0), 32'h6);
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 5; i++) if ($urandom_range(0, 9) == 0) pb[i] = ~pb[i];
            if ($urandom_range(0, 3) == 0) y = 4'($urandom);
            clr = ($urandom_range(0, 99) < 2);
            rst = ($urandom_range(0, 299) == 0);
            cyc(1);
        end
        clr = 0; rst = 0; pb = 0; cyc(D + 6);
        chk("queue_drained", 32'(q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
